// File: rtl/i2c_pkg.sv
// Shared state encoding and byte-framing constants for the I2C byte writer.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_ACK1,
    S_DATA,
    S_ACK2,
    S_STOP
  } i2c_state_t;

  localparam logic I2C_WR_BIT    = 1'b0;
  localparam int   BITS_PER_BYTE = 8;

endpackage

// File: rtl/i2c_byte_writer_timer.sv
// Phase timer for the I2C writer: counts clk_usec ticks within a bus slot
// and flags slot end, the tick after SCL falls, and the ACK sample point.
module i2c_phase_timer
  import i2c_pkg::*;
#(
  parameter  int HALF_US = 5,
  localparam int TW      = $clog2(3 * HALF_US)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clk_usec,
  input  logic          clr,
  input  logic [TW-1:0] slot_len,
  output logic [TW-1:0] tcnt,
  output logic          slot_end,
  output logic          scl_fall_tick,
  output logic          sample_tick
);

  localparam logic [TW-1:0] SAMPLE_PRE = TW'(HALF_US + HALF_US / 2 - 1);

  // clr wins over a coincident tick so every slot starts from zero
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      tcnt <= '0;
    else if (clr)      tcnt <= '0;
    else if (clk_usec) tcnt <= tcnt + TW'(1);
  end

  assign slot_end      = clk_usec && (tcnt == slot_len - TW'(1));
  assign scl_fall_tick = clk_usec && (tcnt == '0);
  assign sample_tick   = clk_usec && (tcnt == SAMPLE_PRE);

endmodule

// File: rtl/i2c_byte_writer.sv
// Single-byte I2C master write: START, address+W, one data byte, STOP.
// Optional I2C_ACK_CHECK_EN: sample ACKs, flag NACK in ack_err, abort to STOP.
//
// state   | meaning
// S_IDLE  | bus released, waiting for start
// S_START | SDA low with SCL high (START condition)
// S_ADDR  | shifting out 7-bit address + W, MSB first
// S_ACK1  | SDA released for slave address ACK
// S_DATA  | shifting out payload byte, MSB first
// S_ACK2  | SDA released for slave data ACK
// S_STOP  | SCL low, SCL high, then SDA high; bus-free time
module i2c_byte_writer
  import i2c_pkg::*;
#(
  parameter int HALF_US = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_usec,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] data,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);

  localparam int              TW       = $clog2(3 * HALF_US);
  localparam int              BW       = $clog2(BITS_PER_BYTE);
  localparam logic [TW-1:0]   HALF     = TW'(HALF_US);
  localparam logic [TW-1:0]   STOP_REL = TW'(HALF_US + HALF_US / 2);
  localparam logic [BW-1:0]   LAST_BIT = BW'(BITS_PER_BYTE - 1);

  i2c_state_t state, state_nxt;

  logic [TW-1:0]            tcnt;
  logic [TW-1:0]            slot_len;
  logic                     slot_end, scl_fall_tick, sample_tick, clr;
  logic [BITS_PER_BYTE-1:0] shift, data_q;
  logic [BW-1:0]            bit_cnt;
  logic                     sda_q;
  logic                     accept, last_bit, nack_stop;

  assign accept   = (state == S_IDLE) && start;
  assign last_bit = (bit_cnt == LAST_BIT);
  assign clr      = slot_end || (state == S_IDLE);

  always_comb begin
    slot_len = TW'(2 * HALF_US);
    case (state)
      S_START: slot_len = TW'(HALF_US);
      S_STOP:  slot_len = TW'(3 * HALF_US);
      default: slot_len = TW'(2 * HALF_US);
    endcase
  end

  i2c_phase_timer #(.HALF_US(HALF_US)) u_timer (
    .clk           (clk),
    .reset_n       (reset_n),
    .clk_usec      (clk_usec),
    .clr           (clr),
    .slot_len      (slot_len),
    .tcnt          (tcnt),
    .slot_end      (slot_end),
    .scl_fall_tick (scl_fall_tick),
    .sample_tick   (sample_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)                state_nxt = S_START;
      S_START: if (slot_end)             state_nxt = S_ADDR;
      S_ADDR:  if (slot_end && last_bit) state_nxt = S_ACK1;
      S_ACK1:  if (slot_end)             state_nxt = nack_stop ? S_STOP : S_DATA;
      S_DATA:  if (slot_end && last_bit) state_nxt = S_ACK2;
      S_ACK2:  if (slot_end)             state_nxt = S_STOP;
      S_STOP:  if (slot_end)             state_nxt = S_IDLE;
      default:                           state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    busy   = 1'b1;
    case (state)
      S_IDLE:  busy   = 1'b0;
      S_START: sda_oe = 1'b1;
      S_STOP: begin
        scl_oe = (tcnt < HALF);
        sda_oe = (tcnt < STOP_REL);
      end
      default: begin
        scl_oe = (tcnt < HALF);
        sda_oe = sda_q;
      end
    endcase
  end

  // SDA only moves one tick after SCL falls; sda_q carries the START low into ADDR
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift   <= '0;
      data_q  <= '0;
      bit_cnt <= '0;
      sda_q   <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= (state == S_STOP) && slot_end;
      if (accept) begin
        shift   <= {addr, I2C_WR_BIT};
        data_q  <= data;
        bit_cnt <= '0;
        sda_q   <= 1'b1;
      end else begin
        case (state)
          S_ADDR, S_DATA: begin
            if (scl_fall_tick) sda_q <= ~shift[BITS_PER_BYTE-1];
            if (slot_end) begin
              shift   <= {shift[BITS_PER_BYTE-2:0], 1'b0};
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
          S_ACK1: begin
            if (scl_fall_tick) sda_q <= 1'b0;
            if (slot_end)      shift <= data_q;
          end
          S_ACK2: if (scl_fall_tick) sda_q <= 1'b0;
          default: ;
        endcase
      end
    end
  end

`ifdef I2C_ACK_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      ack_err <= 1'b0;
    else if (accept)
      ack_err <= 1'b0;
    else if ((state == S_ACK1 || state == S_ACK2) && sample_tick && sda_i)
      ack_err <= 1'b1;
  end
  assign nack_stop = ack_err;
`else
  logic unused_ack_in;
  assign unused_ack_in = sda_i | sample_tick;
  assign ack_err       = 1'b0;
  assign nack_stop     = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_byte_writer.sv
// Self-checking bench for i2c_byte_writer: bus monitor builds a per-transaction
// record at each done pulse, compared against a queue of modelled expectations.
module tb_i2c_byte_writer;

  localparam int HALF_US    = 5;
  localparam int TXN_TICKS  = HALF_US + 18 * 2 * HALF_US + 3 * HALF_US;
  localparam int NACK_TICKS = HALF_US + 9 * 2 * HALF_US + 3 * HALF_US;
  localparam int TICK_DIV   = 4;
  localparam int BUDGET     = 300 * TICK_DIV;

  typedef struct packed {
    logic [7:0]  abyte;
    logic [7:0]  dbyte;
    logic [15:0] ticks;
    logic [7:0]  rises;
    logic        ack;
    logic [7:0]  fall_hi;
    logic [7:0]  rise_hi;
    logic        busy_at_done;
  } rec_t;

  logic       clk = 1'b0, reset_n = 1'b0, clk_usec = 1'b0, start = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] data = '0;
  logic       sda_i;
  logic       scl_oe, sda_oe, busy, done, ack_err;

  int   checks = 0, errors = 0;
  rec_t exp_q[$], obs_q[$];

  int         rise_cnt = 0, tick_cnt = 0, fall_hi = 0, rise_hi = 0;
  logic [7:0] cap_a = '0, cap_d = '0;
  logic       p_scl = 1'b0, p_sda = 1'b0;
  logic       slave_on = 1'b1, ack_drive;

  i2c_byte_writer #(.HALF_US(HALF_US)) dut (
    .clk(clk), .reset_n(reset_n), .clk_usec(clk_usec), .start(start),
    .addr(addr), .data(data), .sda_i(sda_i), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .busy(busy), .done(done), .ack_err(ack_err)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    repeat (TICK_DIV - 1) @(posedge clk);
    #1 clk_usec = 1'b1;
    @(posedge clk);
    #1 clk_usec = 1'b0;
  end

  // slave pulls SDA from the SCL fall after bit 8 until the SCL fall after the ACK clock
  always_comb ack_drive = slave_on &&
    ((((rise_cnt == 8) || (rise_cnt == 17)) && scl_oe) ||
     (((rise_cnt == 9) || (rise_cnt == 18)) && !scl_oe));
  assign sda_i = ~(sda_oe | ack_drive);

  initial forever begin
    rec_t o;
    @(negedge clk);
    if (busy) begin
      if (clk_usec) tick_cnt++;
      if (p_scl && !scl_oe) begin
        rise_cnt++;
        if (rise_cnt >= 1 && rise_cnt <= 8)        cap_a = {cap_a[6:0], ~sda_oe};
        else if (rise_cnt >= 10 && rise_cnt <= 17) cap_d = {cap_d[6:0], ~sda_oe};
      end
      if (!p_scl && !scl_oe && (sda_oe != p_sda)) begin
        if (sda_oe) fall_hi++;
        else        rise_hi++;
      end
    end
    if (done) begin
      o.abyte = cap_a;             o.dbyte = cap_d;
      o.ticks = 16'(tick_cnt);     o.rises = 8'(rise_cnt);
      o.ack = ack_err;             o.fall_hi = 8'(fall_hi);
      o.rise_hi = 8'(rise_hi);     o.busy_at_done = busy;
      obs_q.push_back(o);
    end
    if (!busy) begin
      rise_cnt = 0; tick_cnt = 0; fall_hi = 0; rise_hi = 0; cap_a = '0; cap_d = '0;
    end
    p_scl = scl_oe;
    p_sda = sda_oe;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  function automatic rec_t model(input logic [6:0] a, input logic [7:0] d, input bit slave);
    rec_t r;
    r.abyte = {a, 1'b0}; r.dbyte = d; r.ticks = 16'(TXN_TICKS); r.rises = 8'd19;
    r.ack = 1'b0; r.fall_hi = 8'd1; r.rise_hi = 8'd1; r.busy_at_done = 1'b0;
`ifdef I2C_ACK_CHECK_EN
    if (!slave) begin
      r.dbyte = 8'h00; r.ticks = 16'(NACK_TICKS); r.rises = 8'd10; r.ack = 1'b1;
    end
`else
    if (!slave) r.ack = 1'b0;
`endif
    return r;
  endfunction

  function automatic string fmt(input rec_t r);
    return $sformatf("a=%h d=%h ticks=%0d rises=%0d ack=%b sda_fall_hi=%0d sda_rise_hi=%0d busy_at_done=%b",
                     r.abyte, r.dbyte, r.ticks, r.rises, r.ack, r.fall_hi, r.rise_hi, r.busy_at_done);
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic launch(input logic [6:0] a, input logic [7:0] d);
    addr = a; data = d; start = 1'b1;
    exp_q.push_back(model(a, d, slave_on));
    step();
    start = 1'b0;
  endtask

  task automatic wait_obs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (obs_q.size() > 0) begin ok = 1'b1; break; end
    end
    #1;
  endtask

  task automatic wait_rise(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      step();
      if (rise_cnt >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic seen;
    reset_n = 1'b0; start = 1'b0;
    step(3);
    @(negedge clk);
    checks += 5;
    if (scl_oe  !== 1'b0) begin errors++; $display("FAIL reset_scl_oe got %b expected 0", scl_oe); end
    if (sda_oe  !== 1'b0) begin errors++; $display("FAIL reset_sda_oe got %b expected 0", sda_oe); end
    if (busy    !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    if (done    !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    if (ack_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err got %b expected 0", ack_err); end
    step();
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (200) begin @(negedge clk); seen |= scl_oe | sda_oe | busy | done; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL idle_released got activity=%b expected 0", seen); end
    step();
  endtask

  task automatic test_basic_write();
    bit ok; rec_t o, e;
    slave_on = 1'b1;
    launch(7'h27, 8'hA5);
    @(negedge clk);
    checks += 3;
    if (busy   !== 1'b1) begin errors++; $display("FAIL accept_busy got %b expected 1", busy); end
    if (sda_oe !== 1'b1) begin errors++; $display("FAIL accept_sda_low got %b expected 1", sda_oe); end
    if (scl_oe !== 1'b0) begin errors++; $display("FAIL accept_scl_high got %b expected 0", scl_oe); end
    wait_obs(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_done got timeout expected done"); end
    else begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL basic_txn got %s expected %s", fmt(o), fmt(e)); end
    end
    step(3);
  endtask

  task automatic test_patterns();
    bit ok; rec_t o, e;
    logic [6:0] pa[4];
    logic [7:0] pd[4];
    pa[0] = 7'h00; pd[0] = 8'h00;
    pa[1] = 7'h7F; pd[1] = 8'hFF;
    pa[2] = 7'h55; pd[2] = 8'h3C;
    pa[3] = 7'($urandom); pd[3] = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        // land the request on a clk_usec tick
        for (int k = 0; k < 2 * TICK_DIV; k++) begin
          if (clk_usec) break;
          step();
        end
      end
      launch(pa[i], pd[i]);
      wait_obs(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL pattern%0d_done got timeout expected done", i); end
      else begin
        o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
        if (o !== e) begin errors++; $display("FAIL pattern%0d_txn got %s expected %s", i, fmt(o), fmt(e)); end
      end
      step(2);
    end
  endtask

  task automatic test_ignore_start();
    bit ok; rec_t o, e; logic seen;
    launch(7'h12, 8'h34);
    addr = 7'h70; data = 8'h0F;
    wait_rise(3, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ignore_reach_addr got timeout expected rise 3"); end
    start = 1'b1;
    step();
    start = 1'b0;
    wait_obs(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ignore_done got timeout expected done"); end
    else begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL ignore_txn got %s expected %s", fmt(o), fmt(e)); end
    end
    seen = 1'b0;
    repeat (100) begin @(negedge clk); seen |= busy; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL ignore_no_queue got busy=%b expected 0", seen); end
    step();
  endtask

  task automatic test_back_to_back();
    bit ok; rec_t o, e;
    launch(7'h27, 8'h5A);
    addr = 7'h31; data = 8'hC6; start = 1'b1;
    exp_q.push_back(model(7'h31, 8'hC6, slave_on));
    ok = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_first_done got timeout expected done"); end
    @(posedge clk); #2;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_no_gap got busy=%b expected 1", busy); end
    for (int t = 0; t < 2; t++) begin
      wait_obs(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b%0d_done got timeout expected done", t); end
      else begin
        o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
        if (o !== e) begin errors++; $display("FAIL b2b%0d_txn got %s expected %s", t, fmt(o), fmt(e)); end
      end
    end
    step(3);
  endtask

  task automatic test_reset_mid();
    bit ok; rec_t o, e;
    launch(7'h27, 8'hC3);
    wait_rise(13, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_reach_data got timeout expected rise 13"); end
    step(2);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checks += 3;
    if (scl_oe !== 1'b0) begin errors++; $display("FAIL rstmid_scl_oe got %b expected 0", scl_oe); end
    if (sda_oe !== 1'b0) begin errors++; $display("FAIL rstmid_sda_oe got %b expected 0", sda_oe); end
    if (busy   !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b expected 0", busy); end
    exp_q.delete();
    step(4);
    reset_n = 1'b1;
    step(2);
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_no_done got %0d records expected 0", obs_q.size()); end
    obs_q.delete();
    launch(7'h27, 8'hA5);
    wait_obs(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rstmid_clean_done got timeout expected done"); end
    else begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL rstmid_clean_txn got %s expected %s", fmt(o), fmt(e)); end
    end
    step(3);
  endtask

  task automatic test_nack();
    bit ok; rec_t o, e;
    slave_on = 1'b0;
    launch(7'h3B, 8'h81);
    wait_obs(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL nack_done got timeout expected done"); end
    else begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL nack_txn got %s expected %s", fmt(o), fmt(e)); end
    end
    slave_on = 1'b1;
    step(3);
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_patterns();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_nack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_byte_writer.md
# i2c_byte_writer

Single-byte I2C master write engine for the CLCD I2C path: on a start request it issues START, 7-bit address + W, one data byte, and STOP. The I2C backpack is write-only from this side. The block sits directly downstream of the 1 µs tick generator and consumes its one-cycle `clk_usec` pulse as the only bus time base. It feeds the open-drain pad drivers at the top level. The LCD command sequencer upstream hands it one byte at a time.

## Interface
- `HALF_US`, default 5: SCL half-period in `clk_usec` ticks (5 → 100 kHz); legal range ≥ 2.
- `clk` input 1: system clock, 100 MHz.
- `reset_n` input 1: reset, asynchronous, active-low.
- `clk_usec` input 1: one-`clk`-cycle pulse every 1 µs.
- `start` input 1: transaction request, sampled every `clk`.
- `addr` input 7: slave address, latched on accept.
- `data` input 8: payload byte, latched on accept.
- `sda_i` input 1: synchronised SDA pad level.
- `scl_oe` output 1: 1 = pull SCL low, 0 = release.
- `sda_oe` output 1: 1 = pull SDA low, 0 = release.
- `busy` output 1: transaction in progress.
- `done` output 1: one-cycle pulse at transaction end.
- `ack_err` output 1: a NACK was seen in the last transaction.

## Operation
- States: IDLE, START, ADDR, ACK1, DATA, ACK2, STOP.
- Tick counter `tcnt` advances only on `clk_usec`, is cleared on every state entry, and has width `$clog2(3*HALF_US)`.
- **IDLE**
  - `scl_oe` = 0, `sda_oe` = 0, `busy` = 0.
  - `start` = 1 is accepted: latch `{addr, 1'b0}` as the shift byte and latch `data`, clear `ack_err`, go to START, set `busy` = 1 in the next cycle.
- **START**
  - `scl_oe` = 0 and `sda_oe` = 1 from the first cycle, so SDA falls while SCL is high.
  - After HALF_US ticks, go to ADDR.
- **Bit slot** (ADDR, DATA, ACK1, ACK2), 2·HALF_US ticks long:
  - `scl_oe` = 1 while `tcnt` < HALF_US, else 0.
  - `sda_oe` updates on the tick where `tcnt` becomes 1 (one tick after SCL falls).
  - ADDR and DATA each have 8 slots, MSB first; `sda_oe` = ~bit.
  - ACK slots have `sda_oe` = 0; `sda_i` is sampled on the tick where `tcnt` = HALF_US + HALF_US/2.
- **Transitions**: ADDR → ACK1 → DATA → ACK2 → STOP.
- **STOP**, 3·HALF_US ticks:
  - `tcnt` < HALF_US: SCL low, SDA low.
  - `tcnt` ≥ HALF_US: SCL released.
  - From `tcnt` = HALF_US + HALF_US/2, SDA released (STOP condition).
  - The final span with both lines released provides bus-free time.
  - At the end: `done` pulses, return to IDLE.
- `start` while `busy` is ignored; no queueing.
- `addr` and `data` changes after accept have no effect.
- Asynchronous reset mid-transaction:
  - Outputs return immediately to reset values and the state goes to IDLE.
  - Both lines are released, so the bus may be left mid-byte; the upstream sequencer re-issues.
- Reset values: `scl_oe` = 0, `sda_oe` = 0, `busy` = 0, `done` = 0, `ack_err` = 0.

## Timing
- Accept → `busy` = 1: 1 `clk`.
- Accept → SDA low: 1 `clk`, tick-independent.
- Full transaction is HALF_US + 18·2·HALF_US + 3·HALF_US ticks, i.e. 200 ticks (200 µs) at the default.
- `done` goes high in the `clk` cycle after the final STOP tick, for exactly 1 cycle. In that same cycle `busy` = 0 and the state is IDLE.
- A `start` coincident with `done` is accepted (back-to-back writes).
- `start` coincident with a `clk_usec` tick: accept takes priority, and `tcnt` starts from 0 in START.

## Configuration
- `I2C_ACK_CHECK_EN` defined:
  - A NACK (`sda_i` = 1 at the ACK sample point) in ACK1 or ACK2 sets `ack_err` = 1 and branches directly to STOP at the end of that ACK slot, skipping DATA if the NACK was in ACK1.
  - `ack_err` holds until the next accepted start.
- Undefined:
  - ACK slots release SDA but `sda_i` is never sampled.
  - `ack_err` is constant 0.
  - The sequence is always full length.

## Structure
- Shared package `i2c_pkg`:
  - state enum `i2c_state_t`;
  - localparams `I2C_WR_BIT` = 0 and `BITS_PER_BYTE` = 8.
- Sub-module `i2c_phase_timer`:
  - `clk`/`reset_n`/`clk_usec`/`clr` → `tcnt`;
  - generates `slot_end`, `scl_fall_tick`, `sample_tick` for a given slot length.
- The FSM, shift register and bit counter stay in the top module.

## Test plan
- Reset with `reset_n` = 0: all outputs 0. Release, no `start`: lines stay released indefinitely.
- `addr` = 0x27, `data` = 0xA5, slave ACKs. Required response:
  - SDA bit sequence, sampled on SCL rise, is 0x4E then 0xA5;
  - `done` pulses exactly 200 ticks after START;
  - `ack_err` = 0.
- With `I2C_ACK_CHECK_EN`, no slave (`sda_i` = 1) → `ack_err` = 1, STOP follows ACK1, and `done` arrives after 5 + 9·10 + 15 = 110 ticks. Without the macro, the same stimulus gives 200 ticks and `ack_err` = 0.
- Second `start` pulsed mid-ADDR → ignored; `start` held on the `done` cycle → new transaction begins with no gap beyond the STOP bus-free time.
- `reset_n` asserted during DATA bit 3 → `scl_oe` = `sda_oe` = `busy` = 0 asynchronously; after release, a new `start` runs a clean full transaction.
- Checker across all tests: SDA never changes while SCL is released, except at START and STOP.
